// File: rtl/coin_payout.sv
// Coin hopper payout controller.
// Pays out a requested mix of 5-, 2- and 1-unit coins, largest first.
// Each coin gets one eject pulse. The controller then waits for the hopper
// exit sensor to confirm the coin, retrying once if no confirmation arrives.
// A second missed confirmation for the same coin latches a sticky jam fault.
module coin_payout #(
  parameter int TIMEOUT = 16,
  parameter int GAP     = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       load,
  input  logic [1:0] c1,
  input  logic [1:0] c2,
  input  logic [1:0] c5,
  input  logic       coin_seen,
  output logic       eject1,
  output logic       eject2,
  output logic       eject5,
  output logic       busy,
  output logic       done,
  output logic       fault,
  output logic [4:0] paid
);

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_EJECT = 3'd1;
  localparam logic [2:0] ST_WAIT  = 3'd2;
  localparam logic [2:0] ST_GAP   = 3'd3;
  localparam logic [2:0] ST_FAULT = 3'd4;

  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam int GW = (GAP > 1) ? $clog2(GAP) : 1;
  localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT - 1);
  localparam logic [TW-1:0] TIMER_ONE  = TW'(1);
  localparam logic [GW-1:0] GAP_LAST   = GW'(GAP - 1);
  localparam logic [GW-1:0] GAP_ONE    = GW'(1);
  localparam logic [4:0]    PAID_MAX   = 5'd24;

  // One-hot {5,2,1} selection of the largest denomination still owed.
  function automatic logic [2:0] pick_sel(input logic [1:0] n5,
                                          input logic [1:0] n2,
                                          input logic [1:0] n1);
    logic [2:0] s;
    if (n5 != 2'd0) begin
      s = 3'b100;
    end else if (n2 != 2'd0) begin
      s = 3'b010;
    end else if (n1 != 2'd0) begin
      s = 3'b001;
    end else begin
      s = 3'b000;
    end
    return s;
  endfunction

  // Face value of the one-hot denomination selection.
  function automatic logic [4:0] coin_value(input logic [2:0] sel);
    logic [4:0] v;
    case (sel)
      3'b100:  v = 5'd5;
      3'b010:  v = 5'd2;
      3'b001:  v = 5'd1;
      default: v = 5'd0;
    endcase
    return v;
  endfunction

  logic [2:0]    state_r, state_s;
  logic [1:0]    r5_r, r5_s;
  logic [1:0]    r2_r, r2_s;
  logic [1:0]    r1_r, r1_s;
  logic [4:0]    paid_r, paid_s;
  logic [TW-1:0] timer_r, timer_s;
  logic [GW-1:0] gap_r, gap_s;
  logic          retry_r, retry_s;
  logic [2:0]    eject_r, eject_s;
  logic          busy_r, busy_s;
  logic          done_r, done_s;
  logic          fault_r, fault_s;
  logic [2:0]    sel_cur_s;
  logic [5:0]    paid_sum_s;

  // Next-state and next-output computation for the payout sequencer.
  always_comb begin
    state_s    = state_r;
    r5_s       = r5_r;
    r2_s       = r2_r;
    r1_s       = r1_r;
    paid_s     = paid_r;
    timer_s    = timer_r;
    gap_s      = gap_r;
    retry_s    = retry_r;
    eject_s    = 3'b000;
    busy_s     = busy_r;
    done_s     = 1'b0;
    fault_s    = fault_r;
    sel_cur_s  = pick_sel(r5_r, r2_r, r1_r);
    paid_sum_s = {1'b0, paid_r} + {1'b0, coin_value(sel_cur_s)};

    case (state_r)
      ST_IDLE, ST_FAULT: begin
        if (load) begin
          r5_s    = c5;
          r2_s    = c2;
          r1_s    = c1;
          paid_s  = 5'd0;
          fault_s = 1'b0;
          retry_s = 1'b0;
          timer_s = '0;
          gap_s   = '0;
          if ((c5 == 2'd0) && (c2 == 2'd0) && (c1 == 2'd0)) begin
            // Nothing to pay: complete immediately without going busy.
            done_s  = 1'b1;
            busy_s  = 1'b0;
            state_s = ST_IDLE;
          end else begin
            // Register the first eject now so it appears right after load.
            eject_s = pick_sel(c5, c2, c1);
            busy_s  = 1'b1;
            state_s = ST_EJECT;
          end
        end else begin
          state_s = state_r;
        end
      end

      ST_EJECT: begin
        timer_s = '0;
        state_s = ST_WAIT;
      end

      ST_WAIT: begin
        if (coin_seen) begin
          if (sel_cur_s[2]) begin
            r5_s = r5_r - 2'd1;
          end else if (sel_cur_s[1]) begin
            r2_s = r2_r - 2'd1;
          end else if (sel_cur_s[0]) begin
            r1_s = r1_r - 2'd1;
          end else begin
            r1_s = r1_r;
          end
          paid_s  = (paid_sum_s > {1'b0, PAID_MAX}) ? PAID_MAX : paid_sum_s[4:0];
          retry_s = 1'b0;
          gap_s   = '0;
          state_s = ST_GAP;
        end else if (timer_r == TIMER_LAST) begin
          if (retry_r) begin
            // Second silent timeout for this coin: hopper is jammed.
            fault_s = 1'b1;
            busy_s  = 1'b0;
            state_s = ST_FAULT;
          end else begin
            retry_s = 1'b1;
            eject_s = sel_cur_s;
            state_s = ST_EJECT;
          end
        end else begin
          timer_s = timer_r + TIMER_ONE;
        end
      end

      ST_GAP: begin
        if (gap_r == GAP_LAST) begin
          if (sel_cur_s != 3'b000) begin
            eject_s = sel_cur_s;
            state_s = ST_EJECT;
          end else begin
            done_s  = 1'b1;
            busy_s  = 1'b0;
            state_s = ST_IDLE;
          end
        end else begin
          gap_s = gap_r + GAP_ONE;
        end
      end

      default: begin
        busy_s  = 1'b0;
        state_s = ST_IDLE;
      end
    endcase
  end

  // State and registered-output update; reset abandons any payout.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r <= ST_IDLE;
      r5_r    <= 2'd0;
      r2_r    <= 2'd0;
      r1_r    <= 2'd0;
      paid_r  <= 5'd0;
      timer_r <= '0;
      gap_r   <= '0;
      retry_r <= 1'b0;
      eject_r <= 3'b000;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
      fault_r <= 1'b0;
    end else begin
      state_r <= state_s;
      r5_r    <= r5_s;
      r2_r    <= r2_s;
      r1_r    <= r1_s;
      paid_r  <= paid_s;
      timer_r <= timer_s;
      gap_r   <= gap_s;
      retry_r <= retry_s;
      eject_r <= eject_s;
      busy_r  <= busy_s;
      done_r  <= done_s;
      fault_r <= fault_s;
    end
  end

  assign eject5 = eject_r[2];
  assign eject2 = eject_r[1];
  assign eject1 = eject_r[0];
  assign busy   = busy_r;
  assign done   = done_r;
  assign fault  = fault_r;
  assign paid   = paid_r;

endmodule

// File: tb/tb_coin_payout.sv
// Self-checking bench for coin_payout: directed scenarios plus randomized
// payouts checked cycle by cycle against a transaction-level expectation.
module tb_coin_payout;

  localparam int TIMEOUT = 16;
  localparam int GAP     = 2;

  logic       clk = 1'b0;
  logic       reset;
  logic       load;
  logic [1:0] c1, c2, c5;
  logic       coin_seen;
  logic       eject1, eject2, eject5;
  logic       busy, done, fault;
  logic [4:0] paid;

  int n_tests = 0;
  int n_fail  = 0;

  coin_payout #(.TIMEOUT(TIMEOUT), .GAP(GAP)) dut (
    .clk       (clk),
    .reset     (reset),
    .load      (load),
    .c1        (c1),
    .c2        (c2),
    .c5        (c5),
    .coin_seen (coin_seen),
    .eject1    (eject1),
    .eject2    (eject2),
    .eject5    (eject5),
    .busy      (busy),
    .done      (done),
    .fault     (fault),
    .paid      (paid)
  );

  // Free-running clock.
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Observed outputs packed as {eject5,eject2,eject1,busy,done,fault,paid}.
  function automatic logic [10:0] obs();
    return {eject5, eject2, eject1, busy, done, fault, paid};
  endfunction

  function automatic logic [10:0] expv(input int den, input bit b, input bit d,
                                       input bit f, input int p);
    logic [2:0] ej;
    ej = (den == 5) ? 3'b100 : (den == 2) ? 3'b010 : (den == 1) ? 3'b001 : 3'b000;
    return {ej, b, d, f, p[4:0]};
  endfunction

  task automatic chk(input string tag, input logic [10:0] o, input logic [10:0] e);
    n_tests++;
    assert (o === e) else begin
      n_fail++;
      $error("FAIL %s: observed {ej5,ej2,ej1,busy,done,fault,paid}=%b expected=%b", tag, o, e);
    end
  endtask

  // Runs one payout from IDLE/FAULT. dly: confirm delay in cycles after each
  // eject (0 = random 1..TIMEOUT). miss_first: silent timeouts for the first
  // coin (2 = jam). rnd: random single retries plus ignored noise in gaps.
  task automatic payout(input int n5, input int n2, input int n1, input int dly,
                        input int miss_first, input bit rnd);
    int den[$];
    int paid_exp;
    int misses;
    int k;
    paid_exp = 0;
    repeat (n5) den.push_back(5);
    repeat (n2) den.push_back(2);
    repeat (n1) den.push_back(1);
    c5 = 2'(n5); c2 = 2'(n2); c1 = 2'(n1);
    load = 1'b1;
    step();
    load = 1'b0;
    c5 = 2'($urandom); c2 = 2'($urandom); c1 = 2'($urandom);
    if (den.size() == 0) begin
      chk("zero_load_done", obs(), expv(0, 0, 1, 0, 0));
      step();
      chk("zero_load_after", obs(), expv(0, 0, 0, 0, 0));
      return;
    end
    for (int i = 0; i < den.size(); i++) begin
      misses = (i == 0) ? miss_first : ((rnd && $urandom_range(0, 5) == 0) ? 1 : 0);
      for (int m = 0; m < 2; m++) begin
        chk("eject", obs(), expv(den[i], 1, 0, 0, paid_exp));
        if (m < misses) begin
          for (int j = 1; j <= TIMEOUT; j++) begin
            step();
            chk("wait_silent", obs(), expv(0, 1, 0, 0, paid_exp));
          end
          step();
          if (m == 1) begin
            chk("fault_entry", obs(), expv(0, 0, 0, 1, paid_exp));
            step();
            chk("fault_sticky", obs(), expv(0, 0, 0, 1, paid_exp));
            return;
          end
        end else begin
          k = (dly != 0) ? dly : $urandom_range(1, TIMEOUT);
          for (int j = 1; j <= k; j++) begin
            step();
            chk("wait", obs(), expv(0, 1, 0, 0, paid_exp));
            if (j == k) coin_seen = 1'b1;
          end
          step();
          coin_seen = 1'b0;
          paid_exp += den[i];
          for (int g = 1; g <= GAP; g++) begin
            chk("gap", obs(), expv(0, 1, 0, 0, paid_exp));
            if (rnd) begin
              coin_seen = 1'($urandom);
              load = 1'($urandom);
              c1 = 2'd3; c2 = 2'($urandom); c5 = 2'($urandom);
            end
            step();
            coin_seen = 1'b0;
            load = 1'b0;
          end
          break;
        end
      end
    end
    chk("done", obs(), expv(0, 0, 1, 0, paid_exp));
    step();
    chk("after_done", obs(), expv(0, 0, 0, 0, paid_exp));
  endtask

  // Directed and randomized scenario sequence.
  initial begin
    int r5, r2, r1, mf;
    reset = 1'b0; load = 1'b0; coin_seen = 1'b0;
    c1 = 2'd0; c2 = 2'd0; c5 = 2'd0;
    #12;
    chk("reset_state", obs(), expv(0, 0, 0, 0, 0));
    @(negedge clk);
    reset = 1'b1;
    step();
    chk("first_idle", obs(), expv(0, 0, 0, 0, 0));

    payout(1, 1, 1, 3, 0, 0);          // 5,2,1 in order, paid 5/7/8
    payout(0, 2, 0, 0, 2, 0);          // jam after retry -> fault, paid 0
    payout(0, 0, 1, 1, 0, 0);          // load from FAULT clears it
    payout(3, 3, 3, 0, 0, 0);          // maximum payout, paid 24
    payout(1, 1, 0, 0, 0, 1);          // loads/coin_seen in gaps ignored
    payout(0, 0, 1, TIMEOUT, 0, 0);    // confirmation on the last wait cycle
    payout(0, 1, 1, TIMEOUT, 1, 0);    // retry then last-cycle confirmation

    for (int t = 0; t < 12; t++) begin
      r5 = $urandom_range(0, 3);
      r2 = $urandom_range(0, 3);
      r1 = $urandom_range(0, 3);
      mf = $urandom_range(0, 7);
      mf = (mf == 0) ? 2 : (mf == 1) ? 1 : 0;
      payout(r5, r2, r1, 0, mf, 1);
    end

    // Reset in the middle of the second coin of a two-fives payout.
    c5 = 2'd2; c2 = 2'd0; c1 = 2'd0;
    load = 1'b1;
    step();
    load = 1'b0;
    chk("rst_seq_eject_a", obs(), expv(5, 1, 0, 0, 0));
    step();
    coin_seen = 1'b1;
    step();
    coin_seen = 1'b0;
    repeat (GAP) step();
    chk("rst_seq_eject_b", obs(), expv(5, 1, 0, 0, 5));
    step();
    step();
    #3 reset = 1'b0;
    #1;
    chk("async_reset", obs(), expv(0, 0, 0, 0, 0));
    repeat (2) @(negedge clk);
    reset = 1'b1;
    for (int j = 0; j < 2 * TIMEOUT; j++) begin
      coin_seen = 1'($urandom);
      step();
      chk("post_reset_quiet", obs(), expv(0, 0, 0, 0, 0));
    end
    coin_seen = 1'b0;
    payout(0, 0, 0, 0, 0, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/coin_payout.md
COIN_PAYOUT -- requirements
Module: coin_payout

Interface
REQ-001 Parameter TIMEOUT, default 16: cycles to wait for hopper confirmation after an eject pulse.
REQ-002 Parameter GAP, default 2: idle cycles between a confirmed coin and the next eject.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 load  input  1  one-cycle strobe: change counts valid; start payout.
REQ-006 c1, c2, c5  input  2 each  number of 1-, 2- and 5-unit coins to pay, sampled on load.
REQ-007 coin_seen  input  1  hopper exit sensor; one-cycle pulse per coin physically released.
REQ-008 eject1, eject2, eject5  output  1 each  one-cycle hopper solenoid pulses, registered.
REQ-009 busy  output  1  high from the cycle after an accepted load until done or fault.
REQ-010 done  output  1  one-cycle pulse: payout completed.
REQ-011 fault  output  1  sticky hopper-jam flag.
REQ-012 paid  output  5  running value paid in the current payout, 0..24.

Function
REQ-013 FSM states SHALL be IDLE, EJECT, WAIT, GAP, FAULT; encoding is free.
REQ-014 In IDLE or FAULT, load SHALL latch c5/c2/c1 into remaining counters r5/r2/r1, clear paid and fault, and enter EJECT.
REQ-015 load while busy=1 SHALL be ignored; counters, paid and state SHALL be unaffected.
REQ-016 Load with c1=c2=c5=0 SHALL produce done=1 in the next cycle, no eject, busy stays 0.
REQ-017 Coin order SHALL be largest first: all 5s, then all 2s, then all 1s.
REQ-018 In EJECT, exactly one eject line SHALL pulse for one cycle, for the largest denomination with a nonzero remaining count; the FSM then enters WAIT with the timer cleared.
REQ-019 First eject SHALL be high in the cycle immediately after the edge that sampled load.
REQ-020 In WAIT, coin_seen SHALL decrement the active counter by 1, add its value (5/2/1) to paid, and enter GAP.
REQ-021 coin_seen in the same cycle that the timer reaches TIMEOUT SHALL count as a confirmation.
REQ-022 GAP SHALL last exactly GAP cycles; it then enters EJECT if any counter is nonzero, else asserts done for one cycle, drops busy in that same cycle, and returns to IDLE.
REQ-023 Timer expiry in WAIT without coin_seen SHALL re-pulse the same eject line once (one retry per coin); the retry counter SHALL clear on each confirmed coin.
REQ-024 A second consecutive expiry for the same coin SHALL enter FAULT: fault=1, busy=0, no done, counters and paid held for readout.
REQ-025 coin_seen outside WAIT SHALL be ignored.
REQ-026 paid SHALL never exceed 24; counters SHALL never wrap below 0.
REQ-027 No two eject lines SHALL ever be high in the same cycle.

Reset
REQ-028 reset low SHALL immediately force state IDLE, r1=r2=r5=0, paid=0, busy=0, done=0, fault=0, all eject lines 0, and clear timer and retry counter, regardless of clock.
REQ-029 Reset asserted mid-payout SHALL abandon the payout; no eject pulse SHALL occur until a new load after reset release.
REQ-030 The first rising edge with reset high SHALL be treated as a normal IDLE cycle.

Verification
REQ-031 load c5=1,c2=1,c1=1; coin_seen 3 cycles after each eject -> eject5, eject2, eject1 in that order, each preceded by a 2-cycle gap after the prior confirm; paid 5,7,8; one done pulse.
REQ-032 load c2=2; no coin_seen after first eject2 -> retry eject2 at cycle 17 after the first pulse; still no coin_seen -> fault=1, busy=0, paid=0, r2=2.
REQ-033 FAULT state, then load c1=1 with a prompt coin_seen -> fault clears on load, eject1 pulses, paid=1, done pulses.
REQ-034 load c5=3,c2=3,c1=3, all coins confirmed -> 9 ejects, paid=24, no overlap of eject lines.
REQ-035 Second load during busy with c1=3 -> ignored; only the first payout's coins are ejected.
REQ-036 reset low during WAIT of a c5=2 payout -> outputs zero asynchronously; after release, no eject occurs without a new load; load c1=0,c2=0,c5=0 -> done in the next cycle, no eject.
